// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_dec_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} dec_state_e;

  localparam int NR          = 10;
  localparam int ROUND_KEY_W = 128;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_cipher_core_if.sv
// Block handshake and key-store index bus for the AES-128 inverse cipher core.
interface aes_inv_cipher_core_if;
  logic         start;
  logic [127:0] cipher_text;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         busy;
  logic         plain_valid;
  logic [127:0] plain_text;

  modport slave  (input  start, cipher_text, round_key,
                  output round_num, busy, plain_valid, plain_text);
  modport master (output start, cipher_text, round_key,
                  input  round_num, busy, plain_valid, plain_text);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         last,
  output logic [127:0] result
);

  // Matrix {0e,0b,0d,09} built from x2/x4/x8 xtime chains.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a, x2, x4, x8, m9, mb, md, me;
    a = col;
    for (int i = 0; i < 4; i++) begin
      x2[i] = gf_xtime(a[i]);
      x4[i] = gf_xtime(x2[i]);
      x8[i] = gf_xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    // a[3] is row 0 (most significant byte of the column)
    return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
            m9[3] ^ me[2] ^ mb[1] ^ md[0],
            md[3] ^ m9[2] ^ me[1] ^ mb[0],
            mb[3] ^ md[2] ^ m9[1] ^ me[0]};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] col_in;
    // Row r of column c comes from column (c - r) mod 4 before the right rotate.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign col_in[31-8*r -: 8] =
        inv_sbox(state[127-8*(r+4*((c+4-r)%4)) -: 8]) ^ key[127-8*(r+4*c) -: 8];
    end
    assign result[127-32*c -: 32] = last ? col_in : inv_mix_col(col_in);
  end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decrypt core, one round per clock. Optional abort input
// is enabled by defining AES_INV_ABORT_EN.
module aes_inv_cipher_core
  import aes_dec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
`ifdef AES_INV_ABORT_EN
  input  logic abort,
`endif
  aes_inv_cipher_core_if.slave bus
);

  dec_state_e                state_q, state_d;
  logic [3:0]                rnd_q, rnd_d;
  logic [ROUND_KEY_W-1:0]    state_reg, sreg_d;
  logic [ROUND_KEY_W-1:0]    round_out;

  aes_inv_round u_round (
    .state  (state_reg),
    .key    (bus.round_key),
    .last   (state_q == FINAL),
    .result (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rnd_q     <= 4'(NR);
      state_reg <= '0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      state_reg <= sreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    sreg_d  = state_reg;
    case (state_q)
      IDLE, DONE: begin
        // round_num sits at NR here, so this is the key-10 AddRoundKey
        if (bus.start) begin
          sreg_d  = bus.cipher_text ^ bus.round_key;
          rnd_d   = 4'(NR - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        sreg_d = round_out;
        rnd_d  = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        sreg_d  = round_out;
        rnd_d   = 4'(NR);
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        rnd_d   = 4'(NR);
      end
    endcase
`ifdef AES_INV_ABORT_EN
    if (abort && (state_q == ROUND || state_q == FINAL)) begin
      state_d = IDLE;
      rnd_d   = 4'(NR);
      sreg_d  = state_reg;
    end
`endif
  end

  assign bus.round_num   = rnd_q;
  assign bus.busy        = (state_q == ROUND) || (state_q == FINAL);
  assign bus.plain_valid = (state_q == DONE);
  assign bus.plain_text  = (state_q == DONE) ? state_reg : '0;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed bench for aes_inv_cipher_core using FIPS-197 vectors and a key-store model.
module tb_aes_inv_cipher_core;

  logic clk;
  logic rst_n;
`ifdef AES_INV_ABORT_EN
  logic abort;
`endif
  int checks   = 0;
  int failures = 0;
  int ksel     = 0;

  logic [127:0] rk [2][11];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_inv_cipher_core_if bus ();

  aes_inv_cipher_core dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_INV_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  // Key store: combinational lookup on the core's requested index.
  assign bus.round_key = (bus.round_num <= 4'd10) ? rk[ksel][bus.round_num] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expand_key(input logic [127:0] key, input int sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rn"},   128'(bus.round_num),   128'd10);
    chk({tag, "_busy"}, 128'(bus.busy),        128'd0);
    chk({tag, "_pv"},   128'(bus.plain_valid), 128'd0);
    chk({tag, "_pt"},   bus.plain_text,        128'd0);
  endtask

  // Full decrypt with per-cycle round_num/busy/valid/data trace checks.
  task automatic run_block(input logic [127:0] ct, input int ks,
                           input logic [127:0] exp, input string tag);
    int busy_cnt;
    busy_cnt = 0;
    ksel = ks;
    bus.cipher_text = ct;
    bus.start = 1'b1;
    chk({tag, "_rn_pre"}, 128'(bus.round_num), 128'd10);
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) begin
        bus.start = 1'b0;
        bus.cipher_text = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (bus.busy) busy_cnt++;
      chk($sformatf("%s_rn%0d", tag, k), 128'(bus.round_num),
          (k <= 10) ? 128'(10 - k) : 128'd10);
      chk($sformatf("%s_pv%0d", tag, k), 128'(bus.plain_valid), 128'(k == 11));
      chk($sformatf("%s_pt%0d", tag, k), bus.plain_text, (k == 11) ? exp : 128'd0);
    end
    chk({tag, "_busy_cnt"}, 128'(busy_cnt), 128'd10);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cipher_text = '0;
`ifdef AES_INV_ABORT_EN
    abort = 1'b0;
`endif
    expand_key(KEY_C1, 0);
    expand_key(KEY_B, 1);

    step();
    step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    step();
    chk_idle_outputs("idle");

    // FIPS-197 C.1 and hold in DONE.
    run_block(CT_C1, 0, PT_C1, "c1");
    step();
    step();
    chk("c1_hold_pv", 128'(bus.plain_valid), 128'd1);
    chk("c1_hold_pt", bus.plain_text, PT_C1);

    // start held high during the whole run: ignored while busy.
    bus.cipher_text = CT_C1;
    bus.start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k > 1) bus.cipher_text = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk($sformatf("bs_rn%0d", k), 128'(bus.round_num),
          (k <= 10) ? 128'(10 - k) : 128'd10);
    end
    chk("bs_pv", 128'(bus.plain_valid), 128'd1);
    chk("bs_pt", bus.plain_text, PT_C1);
    bus.start = 1'b0;

    // Back-to-back: start from DONE with the App. B vector.
    run_block(CT_B, 1, PT_B, "b2b");

    // Reset in cycle 5 of a decryption, then a clean C.1 run.
    ksel = 0;
    bus.cipher_text = CT_C1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_busy", 128'(bus.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    chk_idle_outputs("postrst");
    run_block(CT_C1, 0, PT_C1, "c1_after_rst");

`ifdef AES_INV_ABORT_EN
    bus.cipher_text = CT_C1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 128'(bus.busy), 128'd0);
    chk("abort_rn",   128'(bus.round_num), 128'd10);
    chk("abort_pv",   128'(bus.plain_valid), 128'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("abort_pv_quiet%0d", k), 128'(bus.plain_valid), 128'd0);
    end
    run_block(CT_C1, 0, PT_C1, "c1_after_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
